// File: rtl/alu_pkg.sv
// Shared widths and the assembler state encoding for the 16-bit deserializer.
package alu_pkg;
  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;
endpackage

// File: rtl/deserializer16_if.sv
// Serial-in and word-out handshake bundle for deserializer16.
// Valid/ready: a word transfers on a rising edge where word_valid and word_ready
// are both high; word/word_valid stay stable while word_valid=1 and word_ready=0.
// The serial side has no backpressure: every edge with sin_valid=1 consumes sin.
interface deserializer16_if;
  import alu_pkg::*;

  logic              sin;
  logic              sin_valid;
  logic              sof;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output sin, sin_valid, sof, word_ready,
    input  word, word_valid
  );

  modport slave (
    input  sin, sin_valid, sof, word_ready,
    output word, word_valid
  );
endinterface

// File: rtl/deserializer16_bit_index_counter.sv
// Bit-position counter: load-to-1 on frame start, count on enable, wraps 15->0.
module bit_index_counter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load1,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= IDX_W'(1);
    end else if (en) begin
      cnt <= cnt + IDX_W'(1);
    end
  end

  assign tc = (cnt == '1);
endmodule

// File: rtl/deserializer16.sv
// 16:1 serial-to-parallel assembler with frame restart, one-deep output
// register, and a sticky overrun flag when a finished word cannot be held.
module deserializer16
  import alu_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  deserializer16_if.slave  s,
  output logic [IDX_W-1:0] sl,
  output logic             busy,
  output logic             overrun,
  output state_t           state_dbg
);
  localparam logic [IDX_W-1:0] IDX0 = '0;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] assembled;
  logic [WORD_W-1:0] first_word;
  logic              start;
  logic              complete;
  logic              tc;

  // For MSB-first, 15-idx equals the bitwise inverse of a 4-bit index.
  function automatic logic [IDX_W-1:0] pos_of(input logic [IDX_W-1:0] idx);
    return LSB_FIRST ? idx : ~idx;
  endfunction

  assign start     = s.sin_valid & s.sof;
  assign complete  = s.sin_valid & ~s.sof & tc;
  assign state_dbg = state;

  always_comb begin
    assembled             = sreg;
    assembled[pos_of(sl)] = s.sin;
    first_word            = '0;
    first_word[pos_of(IDX0)] = s.sin;
  end

  bit_index_counter u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (s.sin_valid & ~s.sof),
    .load1 (start),
    .cnt   (sl),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sreg         <= '0;
      s.word       <= '0;
      s.word_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (start) begin
        sreg  <= first_word;
        state <= ASSEMBLE;
        busy  <= 1'b1;
      end else if (s.sin_valid) begin
        if (tc) begin
          sreg  <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          sreg  <= assembled;
          state <= ASSEMBLE;
          busy  <= 1'b1;
        end
      end

      // A held, unaccepted word wins over a newly finished one.
      if (complete) begin
        if (!s.word_valid || s.word_ready) begin
          s.word       <= assembled;
          s.word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (s.word_valid && s.word_ready) begin
        s.word_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_deserializer16.sv
// Directed bench: LSB-first and MSB-first instances share one serial stream.
module tb_deserializer16;
  import alu_pkg::*;

  logic clk;
  logic rst;
  logic sin, sin_valid, sof, word_ready;
  int   checks = 0;
  int   errors = 0;

  logic [IDX_W-1:0] sl0, sl1;
  logic             busy0, busy1, ovr0, ovr1;
  state_t           st0, st1;

  deserializer16_if if0 ();
  deserializer16_if if1 ();

  assign if0.sin = sin;  assign if0.sin_valid = sin_valid;
  assign if0.sof = sof;  assign if0.word_ready = word_ready;
  assign if1.sin = sin;  assign if1.sin_valid = sin_valid;
  assign if1.sof = sof;  assign if1.word_ready = word_ready;

  deserializer16 #(.LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .s(if0.slave), .sl(sl0), .busy(busy0),
    .overrun(ovr0), .state_dbg(st0)
  );
  deserializer16 #(.LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .s(if1.slave), .sl(sl1), .busy(busy1),
    .overrun(ovr1), .state_dbg(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: each returns 1 time unit after the rising edge it used
  task automatic send_bit(input logic b, input logic s_of);
    sin = b; sof = s_of; sin_valid = 1'b1;
    @(posedge clk); #1;
    sin_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input logic first_sof);
    for (int i = 0; i < n; i++) send_bit(v[i], (i == 0) ? first_sof : 1'b0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    if (sl0 !== 4'd0)       begin errors++; $display("FAIL reset_sl: got %0d expected 0", sl0); end
    checks++;
    if (busy0 !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++;
    if (if0.word !== 16'h0) begin errors++; $display("FAIL reset_word: got %h expected 0000", if0.word); end
    checks++;
    if (if0.word_valid !== 1'b0 || ovr0 !== 1'b0 || st0 !== IDLE)
      begin errors++; $display("FAIL reset_flags: got v=%b o=%b st=%0d expected 0 0 0", if0.word_valid, ovr0, st0); end
    checks++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alternating();
    word_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    if (sl0 !== 4'd1 || busy0 !== 1'b1 || st0 !== ASSEMBLE)
      begin errors++; $display("FAIL alt_first_bit: got sl=%0d busy=%b expected 1 1", sl0, busy0); end
    checks++;
    send_bits(16'h2AAA, 15, 1'b0);  // remaining bits 0,1,0,1,...
    if (if0.word !== 16'h5555 || if0.word_valid !== 1'b1)
      begin errors++; $display("FAIL alt_word: got %h v=%b expected 5555 v=1", if0.word, if0.word_valid); end
    checks++;
    if (sl0 !== 4'd0 || busy0 !== 1'b0)
      begin errors++; $display("FAIL alt_sl_wrap: got sl=%0d busy=%b expected 0 0", sl0, busy0); end
    checks++;
    if (if1.word !== 16'hAAAA)
      begin errors++; $display("FAIL alt_word_msb: got %h expected aaaa", if1.word); end
    checks++;
    idle_cycle();
    if (if0.word_valid !== 1'b0)
      begin errors++; $display("FAIL alt_valid_one_cycle: got %b expected 0", if0.word_valid); end
    checks++;
  endtask

  task automatic test_msb_first();
    do_reset();
    word_ready = 1'b1;
    send_bits(16'h0001, 16, 1'b0);
    if (if1.word !== 16'h8000 || if1.word_valid !== 1'b1)
      begin errors++; $display("FAIL msb_word: got %h v=%b expected 8000 v=1", if1.word, if1.word_valid); end
    checks++;
    if (if0.word !== 16'h0001)
      begin errors++; $display("FAIL msb_lsb_twin: got %h expected 0001", if0.word); end
    checks++;
  endtask

  task automatic test_gaps();
    logic [15:0] v;
    v = 16'hA5C3;
    word_ready = 1'b1;
    idle_cycle();
    for (int i = 0; i < 16; i++) begin
      send_bit(v[i], 1'b0);
      if (i < 15) begin
        for (int g = 0; g < (i % 4); g++) begin
          idle_cycle();
          if (sl0 !== 4'(i + 1))
            begin errors++; $display("FAIL gap_sl_frozen: got %0d expected %0d", sl0, i + 1); end
          checks++;
        end
      end
    end
    if (if0.word !== 16'hA5C3 || if0.word_valid !== 1'b1)
      begin errors++; $display("FAIL gap_word: got %h v=%b expected a5c3 v=1", if0.word, if0.word_valid); end
    checks++;
  endtask

  task automatic test_overrun();
    do_reset();
    word_ready = 1'b0;
    send_bits(16'h1234, 16, 1'b0);
    if (if0.word !== 16'h1234 || if0.word_valid !== 1'b1 || ovr0 !== 1'b0)
      begin errors++; $display("FAIL ovr_first: got %h v=%b o=%b expected 1234 1 0", if0.word, if0.word_valid, ovr0); end
    checks++;
    send_bits(16'hFFFF, 16, 1'b0);
    if (if0.word !== 16'h1234 || if0.word_valid !== 1'b1 || ovr0 !== 1'b1)
      begin errors++; $display("FAIL ovr_drop: got %h v=%b o=%b expected 1234 1 1", if0.word, if0.word_valid, ovr0); end
    checks++;
    word_ready = 1'b1;
    idle_cycle();
    if (if0.word_valid !== 1'b0 || ovr0 !== 1'b1)
      begin errors++; $display("FAIL ovr_sticky: got v=%b o=%b expected 0 1", if0.word_valid, ovr0); end
    checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    word_ready = 1'b0;
    send_bits(16'h1234, 16, 1'b0);
    send_bits(16'hFFFF, 15, 1'b0);
    word_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    if (if0.word !== 16'hFFFF || if0.word_valid !== 1'b1 || ovr0 !== 1'b0)
      begin errors++; $display("FAIL b2b_word: got %h v=%b o=%b expected ffff 1 0", if0.word, if0.word_valid, ovr0); end
    checks++;
    idle_cycle();
    if (if0.word_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_drain: got v=%b expected 0", if0.word_valid); end
    checks++;
  endtask

  task automatic test_sof_restart();
    do_reset();
    word_ready = 1'b1;
    send_bits(16'h007F, 7, 1'b0);
    if (sl0 !== 4'd7)
      begin errors++; $display("FAIL sof_partial_sl: got %0d expected 7", sl0); end
    checks++;
    send_bits(16'h00F0, 1, 1'b1);
    if (sl0 !== 4'd1 || busy0 !== 1'b1)
      begin errors++; $display("FAIL sof_restart_sl: got sl=%0d busy=%b expected 1 1", sl0, busy0); end
    checks++;
    for (int i = 1; i < 16; i++) send_bit(1'(16'h00F0 >> i), 1'b0);
    if (if0.word !== 16'h00F0 || if0.word_valid !== 1'b1)
      begin errors++; $display("FAIL sof_word: got %h v=%b expected 00f0 1", if0.word, if0.word_valid); end
    checks++;
  endtask

  task automatic test_mid_reset();
    word_ready = 1'b1;
    send_bits(16'h01FF, 9, 1'b0);
    if (sl0 !== 4'd9)
      begin errors++; $display("FAIL midrst_pre_sl: got %0d expected 9", sl0); end
    checks++;
    #1 rst = 1'b0;
    #1;
    if (sl0 !== 4'd0 || busy0 !== 1'b0 || if0.word !== 16'h0 || if0.word_valid !== 1'b0 || ovr0 !== 1'b0)
      begin errors++; $display("FAIL midrst_async: got sl=%0d b=%b w=%h v=%b o=%b expected all 0", sl0, busy0, if0.word, if0.word_valid, ovr0); end
    checks++;
    #1 rst = 1'b1;
    send_bit(1'b1, 1'b0);
    if (sl0 !== 4'd1)
      begin errors++; $display("FAIL midrst_restart_sl: got %0d expected 1", sl0); end
    checks++;
    send_bits(16'h7FFF, 15, 1'b0);
    if (if0.word !== 16'hFFFF || if0.word_valid !== 1'b1)
      begin errors++; $display("FAIL midrst_word: got %h v=%b expected ffff 1", if0.word, if0.word_valid); end
    checks++;
  endtask

  initial begin
    rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; word_ready = 1'b0;
    test_reset();
    test_alternating();
    test_msb_first();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_sof_restart();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
